// File: rtl/add_arbiter_pkg.sv
// ============================================================================
// add_arbiter_pkg : shared helpers and payload type for the add arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package add_arbiter_pkg;

  localparam int DEF_WIDTH = 64;
  localparam int DEF_N_REQ = 4;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  // Request/operand payload at the default configuration
  typedef struct packed {
    logic [DEF_WIDTH-1:0]       a;
    logic [DEF_WIDTH-1:0]       b;
    logic [id_w(DEF_N_REQ)-1:0] id;
  } add_payload_t;

endpackage

`default_nettype wire

// File: rtl/add.sv
// ============================================================================
// add : unsigned WIDTH-bit adder, carry-out dropped
// Rev 1.0
// ============================================================================
`default_nettype none

module add #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/add_arbiter_rr_arbiter.sv
// ============================================================================
// rr_arbiter : round-robin arbiter, grants only when adv is high
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter
  import add_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = id_w(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  // Search starts at ptr and wraps, so the last winner becomes lowest priority
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < N; i++) begin
      int cand;
      cand = (int'(ptr) + i) % N;
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = IW'(cand);
      end
    end
    if (adv && found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (adv && found) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/add_arbiter.sv
// ============================================================================
// add_arbiter : round-robin sharing of one adder among N_REQ requesters
// Option macro ADD_ARBITER_OPREG_EN adds an operand register stage (latency 2)
// Rev 1.0
// ============================================================================
`default_nettype none

module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N_REQ = DEF_N_REQ,
  localparam int ID_W  = id_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [WIDTH-1:0]       rsp_data_o,
  output logic [ID_W-1:0]        rsp_id_o
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [ID_W-1:0]  id;
  } payload_t;

  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [ID_W-1:0]  out_id;
  logic             out_adv;
  logic             arb_adv;
  logic             any_gnt;
  logic [ID_W-1:0]  gnt_idx;
  payload_t         sel;
  payload_t         add_in;
  logic [WIDTH-1:0] sum;

  assign out_adv = !out_valid || rsp_ready_i;
  assign any_gnt = |req_ready_o;

  always_comb begin
    sel    = '0;
    sel.a  = req_a_i[int'(gnt_idx)*WIDTH +: WIDTH];
    sel.b  = req_b_i[int'(gnt_idx)*WIDTH +: WIDTH];
    sel.id = gnt_idx;
  end

  rr_arbiter #(
    .N       (N_REQ)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid_i),
    .adv     (arb_adv),
    .gnt     (req_ready_o),
    .gnt_idx (gnt_idx)
  );

`ifdef ADD_ARBITER_OPREG_EN
  logic     op_valid;
  payload_t op;

  // Operand stage may fill whenever it is empty or moving into the output stage
  assign arb_adv = !op_valid || out_adv;
  assign add_in  = op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op       <= '0;
    end else if (arb_adv) begin
      op_valid <= any_gnt;
      if (any_gnt) begin
        op <= sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (out_adv) begin
      out_valid <= op_valid;
      if (op_valid) begin
        out_data <= sum;
        out_id   <= op.id;
      end
    end
  end
`else
  assign arb_adv = out_adv;
  assign add_in  = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else if (out_adv) begin
      out_valid <= any_gnt;
      if (any_gnt) begin
        out_data <= sum;
        out_id   <= gnt_idx;
      end
    end
  end
`endif

  add #(
    .WIDTH (WIDTH)
  ) u_add (
    .a     (add_in.a),
    .b     (add_in.b),
    .sum   (sum)
  );

  assign rsp_valid_o = out_valid;
  assign rsp_data_o  = out_data;
  assign rsp_id_o    = out_id;

endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
// ============================================================================
// tb_add_arbiter : directed vectors plus a scoreboarded random-backpressure run
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_add_arbiter;

`ifdef ADD_ARBITER_OPREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_a;
  logic [255:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_data;
  logic [1:0]   rsp_id;

  int n_vec = 0;
  int n_err = 0;

  add_arbiter #(
    .WIDTH       (64),
    .N_REQ       (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_id_o    (rsp_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          k;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp_sum;
  } vec_t;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } rsp_t;

  vec_t tab[5];
  rsp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [63:0] a, input logic [63:0] b);
    req_a[k*64 +: 64] = a;
    req_b[k*64 +: 64] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [63:0] ra[4];
  logic [63:0] rb[4];
  logic [3:0]  pend;

  initial begin
    tab[0] = '{2, 64'd5, 64'd7, 64'd12};
    tab[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};
    tab[2] = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0};
    tab[3] = '{1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 64'h2222_2222_2222_2211};
    tab[4] = '{2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000};

    req_a = '0;
    req_b = '0;
    do_reset();
    chk("reset_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_data", rsp_data, 64'd0);
    chk("reset_id", {62'd0, rsp_id}, 64'd0);

    // Single-requester vectors, including carry wrap
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req(tab[i].k, tab[i].a, tab[i].b);
      req_valid = 4'b0001 << tab[i].k;
      #1;
      chk($sformatf("v%0d_ready", i), {60'd0, req_ready}, {60'd0, 4'b0001 << tab[i].k});
      step();
      req_valid = '0;
      #1;
      chk($sformatf("v%0d_ready_drop", i), {60'd0, req_ready}, 64'd0);
      repeat (LAT - 1) step();
      chk($sformatf("v%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("v%0d_data", i), rsp_data, tab[i].exp_sum);
      chk($sformatf("v%0d_id", i), {62'd0, rsp_id}, 64'(tab[i].k));
    end
    step();
    chk("drain_empty", {63'd0, rsp_valid}, 64'd0);

    // All four held valid: grants 0,1,2,3,0 back to back
    do_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, 64'd100 + 64'(k), 64'd1000 * 64'(k));
    req_valid = 4'b1111;
    for (int c = 0; c < 5 + LAT - 1; c++) begin
      #1;
      if (c < 5) chk($sformatf("rr_ready_c%0d", c), {60'd0, req_ready}, {60'd0, 4'b0001 << (c % 4)});
      step();
      if (c + 1 - LAT >= 0) begin
        int g;
        g = (c + 1 - LAT) % 4;
        chk($sformatf("rr_valid_c%0d", c), {63'd0, rsp_valid}, 64'd1);
        chk($sformatf("rr_id_c%0d", c), {62'd0, rsp_id}, 64'(g));
        chk($sformatf("rr_data_c%0d", c), rsp_data, 64'd100 + 64'(g) + 64'd1000 * 64'(g));
      end
    end
    req_valid = '0;
    repeat (3) step();

`ifndef ADD_ARBITER_OPREG_EN
    // Backpressure: held result stays put, nothing granted until drained
    do_reset();
    set_req(0, 64'h11, 64'h22);
    set_req(1, 64'h100, 64'h1);
    set_req(3, 64'h300, 64'h3);
    req_valid = 4'b0001;
    step();
    req_valid = 4'b1010;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_ready_c%0d", c), {60'd0, req_ready}, 64'd0);
      chk($sformatf("bp_valid_c%0d", c), {63'd0, rsp_valid}, 64'd1);
      chk($sformatf("bp_data_c%0d", c), rsp_data, 64'h33);
      chk($sformatf("bp_id_c%0d", c), {62'd0, rsp_id}, 64'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", {60'd0, req_ready}, 64'b0010);
    step();
    req_valid = 4'b1000;
    chk("bp_r1_id", {62'd0, rsp_id}, 64'd1);
    chk("bp_r1_data", rsp_data, 64'h101);
    #1;
    chk("bp_r3_ready", {60'd0, req_ready}, 64'b1000);
    step();
    req_valid = '0;
    chk("bp_r3_id", {62'd0, rsp_id}, 64'd3);
    chk("bp_r3_data", rsp_data, 64'h303);
    step();
`endif

    // Asynchronous reset with a result in flight; ptr returns to 0
    do_reset();
    set_req(0, 64'd1, 64'd2);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (LAT - 1) step();
    chk("ar_pre_valid", {63'd0, rsp_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_valid", {63'd0, rsp_valid}, 64'd0);
    chk("ar_async_data", rsp_data, 64'd0);
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    chk("ar_tie_ready", {60'd0, req_ready}, 64'b0001);
    req_valid = '0;

    // Random backpressure, scoreboard checks order, ids and sums
    do_reset();
    pend = '0;
    for (int cyc = 0; cyc < 320; cyc++) begin
      for (int k = 0; k < 4; k++) begin
        if (!pend[k] && cyc < 250 && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          ra[k] = {$urandom, $urandom};
          rb[k] = {$urandom, $urandom};
          set_req(k, ra[k], rb[k]);
        end
      end
      req_valid = pend;
      rsp_ready = (cyc >= 250) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #7;
      if (!$onehot0(req_ready) || (req_ready & ~pend) != 4'b0000) begin
        chk("rnd_ready_legal", {60'd0, req_ready}, {60'd0, req_ready & pend});
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          chk("rnd_unexpected_rsp", {62'd0, rsp_id}, 64'hDEAD);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rnd_id", {62'd0, rsp_id}, {62'd0, e.id});
          chk("rnd_data", rsp_data, e.data);
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (req_ready[k] && pend[k]) begin
          sb.push_back('{2'(k), ra[k] + rb[k]});
          pend[k] = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
    chk("rnd_sb_empty", 64'(sb.size()), 64'd0);
    chk("rnd_pend_empty", {60'd0, pend}, 64'd0);
    chk("rnd_final_valid", {63'd0, rsp_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
